// File: rtl/clock_pkg.sv
// Shared types and constants for the HH:MM clock set controller.
package clock_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_SET_HR  = 2'b01,
        ST_SET_MIN = 2'b10,
        ST_COMMIT  = 2'b11
    } state_t;

    localparam int HR_TENS_W  = 2;
    localparam int HR_ONES_W  = 4;
    localparam int MIN_TENS_W = 3;
    localparam int MIN_ONES_W = 4;

    localparam logic [HR_TENS_W-1:0]  HR_MAX_TENS      = 2'd2;
    localparam logic [HR_ONES_W-1:0]  HR_MAX_ONES_AT_2 = 4'd3;
    localparam logic [MIN_TENS_W-1:0] MIN_MAX_TENS     = 3'd5;

    // Display digit positions in blank_mask
    localparam int BLK_HR_TENS  = 5;
    localparam int BLK_HR_ONES  = 4;
    localparam int BLK_MIN_TENS = 3;
    localparam int BLK_MIN_ONES = 2;
    localparam int BLK_SEC_TENS = 1;
    localparam int BLK_SEC_ONES = 0;

    localparam logic [5:0] HR_FIELD_MASK  = (6'b1 << BLK_HR_TENS)  | (6'b1 << BLK_HR_ONES);
    localparam logic [5:0] MIN_FIELD_MASK = (6'b1 << BLK_MIN_TENS) | (6'b1 << BLK_MIN_ONES);

    typedef struct packed {
        logic [HR_TENS_W-1:0]  hr_tens;
        logic [HR_ONES_W-1:0]  hr_ones;
        logic [MIN_TENS_W-1:0] min_tens;
        logic [MIN_ONES_W-1:0] min_ones;
    } hhmm_t;

    // BCD hours +1 with 23 -> 00 wrap; minutes untouched
    function automatic hhmm_t inc_hours(input hhmm_t t);
        hhmm_t r;
        r = t;
        if (t.hr_tens == HR_MAX_TENS && t.hr_ones == HR_MAX_ONES_AT_2) begin
            r.hr_tens = '0;
            r.hr_ones = '0;
        end else if (t.hr_ones == 4'd9) begin
            r.hr_ones = '0;
            r.hr_tens = t.hr_tens + 2'd1;
        end else begin
            r.hr_ones = t.hr_ones + 4'd1;
        end
        return r;
    endfunction

    // BCD minutes +1 with 59 -> 00 wrap; hours untouched
    function automatic hhmm_t inc_minutes(input hhmm_t t);
        hhmm_t r;
        r = t;
        if (t.min_ones == 4'd9) begin
            r.min_ones = '0;
            r.min_tens = (t.min_tens == MIN_MAX_TENS) ? 3'd0 : t.min_tens + 3'd1;
        end else begin
            r.min_ones = t.min_ones + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button synchronizer and debouncer with a one-cycle press pulse.
module btn_debounce #(
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // Synchronize, then accept a new level only after it has been stable long enough;
    // press fires in the same cycle the debounced level rises.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                level <= sync2;
                press <= sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/clock_set_ctrl.sv
// Mode/time-set controller: 1 Hz enable, button handling, HH:MM edit and load.
//
//   state      | meaning
//   -----------+-------------------------------------------------------
//   ST_RUN     | clock running, sec_tick generated, INC ignored
//   ST_SET_HR  | editing hours, hours digits blink
//   ST_SET_MIN | editing minutes, minutes digits blink
//   ST_COMMIT  | one cycle, load pulse carries the edited time
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int CLK_HZ       = 100_000_000,
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int BLINK_DIV    = 25_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  btn_mode,
    input  logic                  btn_inc,
    input  logic [HR_TENS_W-1:0]  cur_hr_tens,
    input  logic [HR_ONES_W-1:0]  cur_hr_ones,
    input  logic [MIN_TENS_W-1:0] cur_min_tens,
    input  logic [MIN_ONES_W-1:0] cur_min_ones,
    output logic                  run_en,
    output logic                  sec_tick,
    output logic                  load,
    output logic [HR_TENS_W-1:0]  ld_hr_tens,
    output logic [HR_ONES_W-1:0]  ld_hr_ones,
    output logic [MIN_TENS_W-1:0] ld_min_tens,
    output logic [MIN_ONES_W-1:0] ld_min_ones,
    output logic [5:0]            blank_mask,
    output logic [1:0]            mode
);

    localparam int DIV_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_HZ - 1);
    localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BLK_W-1:0] BLINK_LAST = BLK_W'(BLINK_DIV - 1);

    state_t           state;
    hhmm_t            edit;
    logic [DIV_W-1:0] div;
    logic [BLK_W-1:0] blink_cnt;
    logic             blink_ph;
    logic             blink_wrap;
    logic             blink_ph_next;
    logic             mode_level;
    logic             mode_press;
    logic             inc_level;
    logic             inc_press;
    logic             mode_p;
    logic             inc_p;

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_mode (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_mode),
        .level (mode_level),
        .press (mode_press)
    );

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_inc (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_inc),
        .level (inc_level),
        .press (inc_press)
    );

    // A press is only honoured while its debounced level is high (always true at the pulse)
    assign mode_p = mode_press & mode_level;
    assign inc_p  = inc_press & inc_level;

    // Blink phase that the edited field will show after this cycle
    always_comb begin
        blink_wrap    = (blink_cnt == BLINK_LAST);
        blink_ph_next = blink_ph ^ blink_wrap;
    end

    assign mode = state;

    // Main FSM with all outputs registered alongside the state
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_RUN;
            run_en      <= 1'b0;
            sec_tick    <= 1'b0;
            load        <= 1'b0;
            blank_mask  <= '0;
            ld_hr_tens  <= '0;
            ld_hr_ones  <= '0;
            ld_min_tens <= '0;
            ld_min_ones <= '0;
            edit        <= '0;
            div         <= '0;
            blink_cnt   <= '0;
            blink_ph    <= 1'b0;
        end else begin
            sec_tick <= 1'b0;
            load     <= 1'b0;
            case (state)
                ST_RUN: begin
                    if (mode_p) begin
                        state      <= ST_SET_HR;
                        run_en     <= 1'b0;
                        div        <= '0;
                        edit       <= {cur_hr_tens, cur_hr_ones, cur_min_tens, cur_min_ones};
                        blink_cnt  <= '0;
                        blink_ph   <= 1'b0;
                        blank_mask <= '0;
                    end else begin
                        run_en     <= 1'b1;
                        blank_mask <= '0;
                        // divider only advances once run_en is already visible
                        if (run_en) begin
                            if (div == DIV_LAST) begin
                                div      <= '0;
                                sec_tick <= 1'b1;
                            end else begin
                                div <= div + 1'b1;
                            end
                        end
                    end
                end
                ST_SET_HR: begin
                    if (mode_p) begin
                        state      <= ST_SET_MIN;
                        blink_cnt  <= '0;
                        blink_ph   <= 1'b0;
                        blank_mask <= '0;
                    end else begin
                        if (inc_p) edit <= inc_hours(edit);
                        blink_cnt  <= blink_wrap ? '0 : blink_cnt + 1'b1;
                        blink_ph   <= blink_ph_next;
                        blank_mask <= blink_ph_next ? HR_FIELD_MASK : 6'b0;
                    end
                end
                ST_SET_MIN: begin
                    if (mode_p) begin
                        state       <= ST_COMMIT;
                        load        <= 1'b1;
                        ld_hr_tens  <= edit.hr_tens;
                        ld_hr_ones  <= edit.hr_ones;
                        ld_min_tens <= edit.min_tens;
                        ld_min_ones <= edit.min_ones;
                        blank_mask  <= '0;
                    end else begin
                        if (inc_p) edit <= inc_minutes(edit);
                        blink_cnt  <= blink_wrap ? '0 : blink_cnt + 1'b1;
                        blink_ph   <= blink_ph_next;
                        blank_mask <= blink_ph_next ? MIN_FIELD_MASK : 6'b0;
                    end
                end
                ST_COMMIT: begin
                    state      <= ST_RUN;
                    run_en     <= 1'b1;
                    div        <= '0;
                    blank_mask <= '0;
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

endmodule
